// File: rtl/sprite_image_writer.sv
// -----------------------------------------------------------------------------
// sprite_image_writer
//
// Loads one palette-indexed sprite frame from a raster-order pixel stream into
// the write port of the image BRAM. The BRAM address is linear
// (row*WIDTH + col). It is built from a running address plus a row-base
// register, so no multiplier is needed. Line and frame structure is checked,
// and any violation raises a sticky error flag.
//
// Ports
//   pixel_clk_in     single clock, rising edge
//   rst_in           synchronous active-high reset
//   arm_in           one-cycle pulse, requests capture of one frame (IDLE only)
//   pixel_in         8-bit palette index
//   pixel_valid_in   source presents a beat
//   pixel_ready_out  block accepts a beat (transfer = valid & ready)
//   sof_in           beat is the first pixel of a frame
//   eol_in           beat is the last pixel of a line
//   addr_out         BRAM write address
//   data_out         BRAM write data
//   we_out           BRAM write enable, one cycle per written beat
//   busy_out         high while waiting for SOF or writing
//   done_out         one-cycle pulse on frame completion
//   err_out          sticky structural error, cleared by an accepted arm
//   frame_count_out  completed frames, wraps at 16 bits
// -----------------------------------------------------------------------------
module sprite_image_writer #(
    parameter  int WIDTH  = 256,
    parameter  int HEIGHT = 256,
    localparam int AW     = $clog2(WIDTH * HEIGHT)
) (
    input  logic          pixel_clk_in,
    input  logic          rst_in,
    input  logic          arm_in,
    input  logic [7:0]    pixel_in,
    input  logic          pixel_valid_in,
    output logic          pixel_ready_out,
    input  logic          sof_in,
    input  logic          eol_in,
    output logic [AW-1:0] addr_out,
    output logic [7:0]    data_out,
    output logic          we_out,
    output logic          busy_out,
    output logic          done_out,
    output logic          err_out,
    output logic [15:0]   frame_count_out
);

    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
    localparam logic [AW-1:0] WIDTH_A  = AW'(WIDTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        WRITE    = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t        state_r, state_s;
    logic [CW-1:0] col_r, col_s;
    logic [RW-1:0] row_r, row_s;
    logic [AW-1:0] addr_r, addr_s;
    logic [AW-1:0] row_base_r, row_base_s;
    logic [AW-1:0] wr_addr_s, wr_addr_r;
    logic [7:0]    wr_data_r;
    logic          drop_r, drop_s;
    logic          err_r, err_s;
    logic [15:0]   frame_count_r, frame_count_s;
    logic          we_s, we_r;
    logic          ready_r, busy_r, done_r;
    logic          transfer_s, start_s, line_end_s;

    // Next-state, address generation and structural checks
    always_comb begin
        state_s       = state_r;
        col_s         = col_r;
        row_s         = row_r;
        addr_s        = addr_r;
        row_base_s    = row_base_r;
        drop_s        = drop_r;
        err_s         = err_r;
        frame_count_s = frame_count_r;
        we_s          = 1'b0;
        wr_addr_s     = addr_r;
        start_s       = 1'b0;
        line_end_s    = 1'b0;
        // ready_r is high only in WAIT_SOF and WRITE, so no transfer elsewhere
        transfer_s    = pixel_valid_in & ready_r;

        case (state_r)
            IDLE: begin
                if (arm_in) begin
                    state_s = WAIT_SOF;
                    err_s   = 1'b0;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT_SOF: begin
                // beats without SOF are accepted and discarded
                if (transfer_s && sof_in) begin
                    start_s = 1'b1;
                end else begin
                    start_s = 1'b0;
                end
            end
            WRITE: begin
                if (!transfer_s) begin
                    state_s = WRITE;
                end else if (sof_in) begin
                    // unexpected SOF restarts the frame from address 0
                    start_s = 1'b1;
                    err_s   = 1'b1;
                end else if (drop_r) begin
                    // overlong line: discard beats up to and including EOL
                    if (eol_in) begin
                        drop_s     = 1'b0;
                        line_end_s = 1'b1;
                    end else begin
                        drop_s = 1'b1;
                    end
                end else begin
                    we_s      = 1'b1;
                    wr_addr_s = addr_r;
                    if (col_r == COL_LAST) begin
                        if (eol_in) begin
                            line_end_s = 1'b1;
                        end else begin
                            err_s  = 1'b1;
                            drop_s = 1'b1;
                        end
                    end else if (eol_in) begin
                        // short line: leave the rest of the row untouched
                        err_s      = 1'b1;
                        line_end_s = 1'b1;
                    end else begin
                        col_s  = col_r + CW'(1);
                        addr_s = addr_r + AW'(1);
                    end
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        if (start_s) begin
            state_s    = WRITE;
            we_s       = 1'b1;
            wr_addr_s  = AW'(0);
            row_s      = RW'(0);
            row_base_s = AW'(0);
            drop_s     = 1'b0;
            if (eol_in) begin
                // SOF+EOL on one beat is a short row 0; HEIGHT>=2 so never last
                err_s      = 1'b1;
                row_s      = RW'(1);
                row_base_s = WIDTH_A;
                addr_s     = WIDTH_A;
                col_s      = CW'(0);
            end else begin
                col_s  = CW'(1);
                addr_s = AW'(1);
            end
        end else if (line_end_s) begin
            if (row_r == ROW_LAST) begin
                state_s       = DONE;
                frame_count_s = frame_count_r + 16'd1;
            end else begin
                row_s      = row_r + RW'(1);
                row_base_s = row_base_r + WIDTH_A;
                addr_s     = row_base_r + WIDTH_A;
                col_s      = CW'(0);
            end
        end else begin
            frame_count_s = frame_count_r;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state_r       <= IDLE;
            col_r         <= CW'(0);
            row_r         <= RW'(0);
            addr_r        <= AW'(0);
            row_base_r    <= AW'(0);
            drop_r        <= 1'b0;
            err_r         <= 1'b0;
            frame_count_r <= 16'd0;
            we_r          <= 1'b0;
            wr_addr_r     <= AW'(0);
            wr_data_r     <= 8'd0;
            ready_r       <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            col_r         <= col_s;
            row_r         <= row_s;
            addr_r        <= addr_s;
            row_base_r    <= row_base_s;
            drop_r        <= drop_s;
            err_r         <= err_s;
            frame_count_r <= frame_count_s;
            we_r          <= we_s;
            if (we_s) begin
                wr_addr_r <= wr_addr_s;
                wr_data_r <= pixel_in;
            end else begin
                wr_addr_r <= wr_addr_r;
                wr_data_r <= wr_data_r;
            end
            // decoded from the next state so they line up with state_r
            ready_r <= (state_s == WAIT_SOF) || (state_s == WRITE);
            busy_r  <= (state_s == WAIT_SOF) || (state_s == WRITE);
            done_r  <= (state_s == DONE);
        end
    end

    assign pixel_ready_out = ready_r;
    assign busy_out        = busy_r;
    assign done_out        = done_r;
    assign err_out         = err_r;
    assign frame_count_out = frame_count_r;
    assign we_out          = we_r;
    assign addr_out        = wr_addr_r;
    assign data_out        = wr_data_r;

endmodule

// File: tb/tb_sprite_image_writer.sv
// -----------------------------------------------------------------------------
// Testbench for sprite_image_writer (WIDTH=4, HEIGHT=3).
// A reference model tracks row/column of the frame and predicts each BRAM
// write as row*WIDTH+col. Predicted writes go into a queue, and a negedge
// monitor pops and compares them whenever we_out is high.
// -----------------------------------------------------------------------------
module tb_sprite_image_writer;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int AW = $clog2(W * H);

    logic          clk = 1'b0;
    logic          rst_in, arm_in, pixel_valid_in, sof_in, eol_in;
    logic [7:0]    pixel_in;
    logic          pixel_ready_out, we_out, busy_out, done_out, err_out;
    logic [AW-1:0] addr_out;
    logic [7:0]    data_out;
    logic [15:0]   frame_count_out;

    sprite_image_writer #(.WIDTH(W), .HEIGHT(H)) dut (
        .pixel_clk_in    (clk),
        .rst_in          (rst_in),
        .arm_in          (arm_in),
        .pixel_in        (pixel_in),
        .pixel_valid_in  (pixel_valid_in),
        .pixel_ready_out (pixel_ready_out),
        .sof_in          (sof_in),
        .eol_in          (eol_in),
        .addr_out        (addr_out),
        .data_out        (data_out),
        .we_out          (we_out),
        .busy_out        (busy_out),
        .done_out        (done_out),
        .err_out         (err_out),
        .frame_count_out (frame_count_out)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int dut_done = 0;

    // model: 0 idle, 1 waiting for SOF, 2 writing
    int m_state, m_row, m_col, m_fc, exp_done;
    bit m_drop, m_err;
    int exp_addr_q[$];
    int exp_data_q[$];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic void model_reset();
        m_state = 0; m_row = 0; m_col = 0; m_fc = 0; m_drop = 0; m_err = 0;
    endfunction

    function automatic void finish_line();
        if (m_row == H - 1) begin
            m_state = 0;
            m_fc++;
            exp_done++;
        end else begin
            m_row++;
            m_col = 0;
        end
    endfunction

    function automatic void model_beat(int px, bit sof, bit eol);
        if (m_state == 1 && !sof) return;
        if (sof) begin
            if (m_state == 2) m_err = 1;
            m_state = 2; m_row = 0; m_col = 0; m_drop = 0;
        end else if (m_drop) begin
            if (eol) begin
                m_drop = 0;
                finish_line();
            end
            return;
        end
        exp_addr_q.push_back(m_row * W + m_col);
        exp_data_q.push_back(px);
        if (eol && m_col < W - 1) begin
            m_err = 1;
            finish_line();
        end else if (m_col == W - 1) begin
            if (eol) finish_line();
            else begin m_err = 1; m_drop = 1; end
        end else begin
            m_col++;
        end
    endfunction

    // scoreboard monitor: every write must match the oldest prediction
    always @(negedge clk) begin
        if (done_out) dut_done++;
        if (we_out) begin
            if (exp_addr_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0d data %0d expected no write", addr_out, data_out);
            end else begin
                check("write_addr", 32'(addr_out), exp_addr_q.pop_front());
                check("write_data", 32'(data_out), exp_data_q.pop_front());
            end
        end
    end

    task automatic do_arm();
        @(negedge clk);
        arm_in = 1'b1;
        if (m_state == 0) begin
            m_state = 1;
            m_err = 0;
        end
        @(negedge clk);
        arm_in = 1'b0;
    endtask

    task automatic send_beat(input int px, input bit sof, input bit eol, input bit gaps);
        int g = 0;
        while (gaps && g < 4 && $urandom_range(0, 1) == 1) begin
            @(negedge clk);
            pixel_valid_in = 1'b0;
            sof_in = 1'($urandom_range(0, 1));
            eol_in = 1'($urandom_range(0, 1));
            pixel_in = 8'($urandom_range(0, 255));
            g++;
        end
        @(negedge clk);
        pixel_valid_in = 1'b1;
        pixel_in = 8'(px);
        sof_in = sof;
        eol_in = eol;
        check("ready", 32'(pixel_ready_out), 32'(m_state != 0));
        if (pixel_ready_out && m_state != 0) model_beat(px, sof, eol);
    endtask

    task automatic send_row(input int r, input int n, input int eol_at, input bit seq, input bit gaps);
        for (int c = 0; c < n; c++)
            send_beat(seq ? (r * W + c) : int'($urandom_range(0, 255)),
                      (r == 0 && c == 0), (c == eol_at), gaps);
    endtask

    task automatic send_frame(input bit seq, input bit gaps);
        for (int r = 0; r < H; r++) send_row(r, W, W - 1, seq, gaps);
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        pixel_valid_in = 1'b0;
        sof_in = 1'b0;
        eol_in = 1'b0;
    endtask

    task automatic checkpoint(input string tag);
        idle_cycle();
        repeat (3) @(negedge clk);
        $display("[TB] checkpoint %s", tag);
        check("queue_empty", 32'(exp_addr_q.size()), 32'd0);
        check("done_count", 32'(dut_done), 32'(exp_done));
        check("err", 32'(err_out), 32'(m_err));
        check("frame_count", 32'(frame_count_out), 32'(m_fc & 16'hFFFF));
        check("busy", 32'(busy_out), 32'(m_state != 0));
        check("we_idle", 32'(we_out), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        pixel_valid_in = 1'b0;
        rst_in = 1'b1;
        model_reset();
        @(negedge clk);
        check("rst_we", 32'(we_out), 32'd0);
        check("rst_ready", 32'(pixel_ready_out), 32'd0);
        check("rst_busy", 32'(busy_out), 32'd0);
        check("rst_err", 32'(err_out), 32'd0);
        check("rst_fc", 32'(frame_count_out), 32'd0);
        rst_in = 1'b0;
    endtask

    initial begin
        rst_in = 1'b1; arm_in = 1'b0; pixel_valid_in = 1'b0;
        pixel_in = 8'd0; sof_in = 1'b0; eol_in = 1'b0;
        model_reset();
        exp_done = 0;
        repeat (3) @(negedge clk);
        check("reset_ready", 32'(pixel_ready_out), 32'd0);
        check("reset_busy", 32'(busy_out), 32'd0);
        check("reset_we", 32'(we_out), 32'd0);
        check("reset_done", 32'(done_out), 32'd0);
        check("reset_err", 32'(err_out), 32'd0);
        check("reset_fc", 32'(frame_count_out), 32'd0);
        check("reset_addr", 32'(addr_out), 32'd0);
        check("reset_data", 32'(data_out), 32'd0);
        @(negedge clk);
        rst_in = 1'b0;

        // clean frame, data = address
        do_arm();
        send_frame(1'b1, 1'b0);
        checkpoint("clean_frame");

        // beats before SOF are dropped
        do_arm();
        for (int i = 0; i < 3; i++) send_beat(int'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
        send_frame(1'b0, 1'b0);
        checkpoint("pre_sof_drop");

        // short row 1, plus an arm mid-frame that must be ignored
        do_arm();
        send_row(0, W, W - 1, 1'b0, 1'b0);
        send_row(1, 2, 1, 1'b0, 1'b0);
        idle_cycle();
        do_arm();
        send_row(2, W, W - 1, 1'b0, 1'b0);
        checkpoint("early_eol");

        // long row 0
        do_arm();
        send_row(0, W + 2, W + 1, 1'b0, 1'b0);
        send_row(1, W, W - 1, 1'b0, 1'b0);
        send_row(2, W, W - 1, 1'b0, 1'b0);
        checkpoint("late_eol");

        // valid gaps on a clean frame
        do_arm();
        send_frame(1'b1, 1'b1);
        checkpoint("gapped_frame");

        // SOF mid-frame restarts at address 0
        do_arm();
        send_row(0, W, W - 1, 1'b0, 1'b0);
        send_beat(int'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
        send_frame(1'b0, 1'b0);
        checkpoint("sof_restart");

        // reset in the middle of row 1, then a full frame
        do_arm();
        send_row(0, W, W - 1, 1'b0, 1'b0);
        send_row(1, 2, -1, 1'b0, 1'b0);
        do_reset();
        do_arm();
        send_frame(1'b0, 1'b1);
        checkpoint("reset_rearm");

        // randomized structure
        for (int k = 0; k < 4; k++) begin
            do_reset();
            do_arm();
            for (int i = 0; i < 40; i++)
                send_beat(int'($urandom_range(0, 255)),
                          (i == 0) || ($urandom_range(0, 15) == 0),
                          ($urandom_range(0, 3) == 0), 1'b1);
            checkpoint("random_structure");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_image_writer.md
Name: sprite_image_writer

Overview:
- Loads a palette-indexed sprite image into the write port of the image BRAM. The display-side sprite reader fetches from that BRAM.
- Accepts a raster-order pixel stream of 8-bit palette indices with a valid/ready handshake plus start-of-frame and end-of-line markers.
- Generates linear BRAM addresses (row*WIDTH + col), checks line and frame structure, and reports completion, errors and frame count.
- Sits between a pixel source (UART/camera/test loader) and the image memory.

Parameters:
- WIDTH, 256, sprite width in pixels (>=2)
- HEIGHT, 256, sprite height in lines (>=2)
- AW = $clog2(WIDTH*HEIGHT), derived localparam, address width

Ports:
- pixel_clk_in  in  1  single clock; all logic on rising edge
- rst_in  in  1  synchronous active-high reset
- arm_in  in  1  one-cycle pulse; requests capture of one frame
- pixel_in  in  8  palette index
- pixel_valid_in  in  1  source has a beat
- pixel_ready_out  out  1  block accepts a beat; transfer = valid & ready
- sof_in  in  1  beat is first pixel of frame (qualified by transfer)
- eol_in  in  1  beat is last pixel of a line (qualified by transfer)
- addr_out  out  AW  BRAM write address
- data_out  out  8  BRAM write data
- we_out  out  1  BRAM write enable
- busy_out  out  1  high in WAIT_SOF and WRITE
- done_out  out  1  one-cycle pulse on frame completion
- err_out  out  1  sticky structural error; cleared by an accepted arm_in
- frame_count_out  out  16  completed frames, wraps at 65535->0

Behaviour:
- Reset values (cycle after rst_in sampled high):
  - state=IDLE
  - all outputs 0, including frame_count_out and err_out
  - reset mid-frame abandons the frame; no further we_out
- States:
  - IDLE: ready=0. arm_in -> WAIT_SOF; clears err_out.
  - WAIT_SOF: ready=1. Beats without sof_in are dropped (no write). A transfer with sof_in writes addr 0, sets col=1, row=0 -> WRITE.
  - WRITE: ready=1. Each transfer writes pixel_in at the current address; col and address increment.
  - DONE: ready=0 for exactly one cycle; done_out=1; frame_count_out+1 -> IDLE.
- arm_in outside IDLE is ignored (err_out is not cleared).
- Write timing: addr_out, data_out and we_out are registered, asserted the cycle after the transfer. we_out stays high at most one cycle per transfer; back-to-back transfers give back-to-back writes.
- Addressing: running address register plus row_base register; no multiplier. Next row: row_base += WIDTH, addr = row_base.
- Line end, normal: transfer at col==WIDTH-1 with eol_in=1 -> next row, col=0.
- Line end, early: eol_in at col<WIDTH-1 -> pixel written, remaining row entries untouched, next row, err_out=1.
- Line end, late: transfer at col==WIDTH-1 with eol_in=0 -> pixel written, err_out=1.
  - State enters a drop sub-mode: subsequent beats are accepted but not written until a beat with eol_in.
  - That eol beat is also dropped; then next row.
- Frame end: last pixel of row HEIGHT-1 (col==WIDTH-1, or early eol) -> DONE next cycle.
  - In the late case, DONE is entered after the dropped eol beat.
- sof_in during WRITE: restart at addr 0 (beat written there), row=col=0 then col=1, err_out=1.
- sof_in and eol_in on the same beat: sof handling first, then eol applies (early-eol rule) when WIDTH>1.
- pixel_valid_in low: no state change; the handshake never drops a beat while ready=1.
- frame_count_out increments only on DONE, never on an aborted frame.

Test Plan:
- WIDTH=4, HEIGHT=3. Arm, stream 12 beats (values 0..11, sof on beat 0, eol on beats 3/7/11, valid held high) -> writes addr k=data k for k=0..11 on consecutive cycles; done_out pulses once; frame_count_out=1; err_out=0.
- Arm, 3 non-sof beats then a valid frame -> first 3 beats produce no we_out; frame lands at addr 0..11; err_out=0.
- Early eol: row 1 eol after 2 pixels -> addrs 4,5 written, next write addr 8; err_out=1; done still pulses after 10 writes.
- Late eol: row 0 gets 6 beats, eol on the 6th -> addrs 0..3 written, beats 5-6 dropped, next write addr 4; err_out=1.
- Random valid gaps (~50% duty) on a full frame -> identical address/data sequence to scenario 1; no duplicate or missing we_out.
- rst_in asserted mid-row 1 -> next cycle we_out=0, ready=0, busy_out=0; re-arm and a full frame -> frame_count_out=1, err_out=0.
